id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port IInst, input, 16 bits: instruction; [15:12] opcode, [11:9] rd, [8:6] ra, [5:3] rb, [7:0] imm (LDI only).
REQ-004 SHALL have ports IValid (input, 1) and OReady (output, 1): fetch handshake; an instruction is accepted when both are 1 on a clock edge.
REQ-005 SHALL have ports IWen (input, 1), IWaddr (input, 3) and IWdata (input, 8): register writeback port from the downstream stage.
REQ-006 SHALL have port IStall, input, 1 bit: EXE hold; when 1, all ID/EX output registers hold their values.
REQ-007 SHALL have ports ORa and ORb, output, 8 bits each: operands to EXE Ira/Irb.
REQ-008 SHALL have port OOPALU, output, 4 bits: ALU opcode to EXE OPALU.
REQ-009 SHALL have ports ONFCR and OZFCR, output, 1 bit each: N/Z flag-capture enables to EXE.
REQ-010 SHALL have ports ODst (output, 3), OWen (output, 1), OValid (output, 1) and OHalt (output, 1): destination register, writeback enable, slot valid, halted.

Function
REQ-011 SHALL contain an 8x8-bit register file, written on the clock edge when IWen=1.
REQ-012 SHALL decode opcodes 1..9 as ALU ops: OOPALU=opcode, ORa=R[ra], ORb=R[rb], OWen=1, ONFCR=OZFCR=1.
REQ-013 SHALL decode opcode 0xA (LDI) as: OOPALU=0 (pass-B), ORb=imm, ORa=0, OWen=1, ONFCR=OZFCR=0.
REQ-014 SHALL decode opcodes 0x0, 0xB-0xD and 0xF as NOP: OValid=1, OWen=0, flag enables 0, OOPALU=0.
REQ-015 SHALL decode opcode 0xE as HALT: the instruction issues as a NOP, then the FSM enters HALT.
REQ-016 SHALL have latency 1: an instruction accepted at edge N appears on the outputs after edge N.
REQ-017 SHALL implement FSM states RUN, BUBBLE and HALT; reset enters RUN.
REQ-018 In RUN, SHALL go to BUBBLE when IValid=1, IStall=0, the current output has OValid=1 and OWen=1, and ra or rb (as used by the opcode) equals ODst; SHALL load OValid=0 and drive OReady=0 while doing so.
REQ-019 In BUBBLE, SHALL issue the held instruction and return to RUN, with OReady=1.
REQ-020 On a valid HALT issue, SHALL enter HALT; in HALT, OReady=0, OHalt=1 and OValid=0; only reset exits HALT.
REQ-021 When IStall=1, SHALL drive OReady=0 and hold the FSM and all outputs; IStall takes priority over hazard detection.
REQ-022 When IValid=0 in RUN with IStall=0, SHALL load a bubble (OValid=0, OWen=0).
REQ-023 SHALL drive OReady combinationally: 1 only in RUN with IStall=0 and no hazard.

Reset
REQ-024 While rst=0, SHALL clear all outputs to 0, clear the FSM to RUN, and clear the register file to 0.
REQ-025 Reset mid-bubble or in HALT SHALL discard the held instruction; OReady SHALL go to 1 in the first cycle after rst rises.

Configuration
REQ-026 With ID_BYPASS_EN defined, a read of register r in the same cycle as IWen=1 with IWaddr=r SHALL return IWdata.
REQ-027 Without ID_BYPASS_EN, such a read SHALL return the old value, and the BUBBLE state SHALL last two cycles instead of one.

Structure
REQ-028 Opcode constants, FSM state encodings and field bit positions SHALL reside in a shared package id_pkg.
REQ-029 The register file SHALL be a sub-module id_regfile (2 read ports, 1 write port, optional bypass).

Verification
REQ-030 Test: write R1=2 and R2=2, then issue ADD r3,r1,r2 (0x1650) -> next cycle ORa=2, ORb=2, OOPALU=1, ODst=3, OWen=1, ONFCR=OZFCR=1.
REQ-031 Test: issue LDI r4,0x06 (0xA806) -> ORb=6, OOPALU=0, ONFCR=0, OWen=1.
REQ-032 Test: issue ADD r3,.. immediately followed by SUB r5,r3,r1 -> one bubble cycle (OValid=0, OReady=0), then SUB issues using the bypassed writeback value.
REQ-033 Test: hold IStall=1 for 3 cycles -> outputs constant and OReady=0; on release, the next instruction issues.
REQ-034 Test: issue HALT (0xE000) -> OHalt=1 and OReady=0 indefinitely; pulse rst low -> RUN, all outputs 0, registers 0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode constants for the instruction-decode stage: instruction
// field positions, opcode values, FSM state encoding and the ID/EX slot record.
package id_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  localparam int NREGS  = 8;

  // Instruction field bit positions
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RA_HI  = 8;
  localparam int RA_LO  = 6;
  localparam int RB_HI  = 5;
  localparam int RB_LO  = 3;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Opcode values
  localparam logic [3:0] OP_ALU_FIRST = 4'h1;
  localparam logic [3:0] OP_ALU_LAST  = 4'h9;
  localparam logic [3:0] OP_LDI       = 4'hA;
  localparam logic [3:0] OP_HALT      = 4'hE;
  localparam logic [3:0] ALU_PASS_B   = 4'h0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_HALT   = 2'd2
  } id_state_e;

  // Everything the stage hands to EXE in one slot
  typedef struct packed {
    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rb;
    logic [3:0]        opalu;
    logic              nfcr;
    logic              zfcr;
    logic [REG_AW-1:0] dst;
    logic              wen;
    logic              valid;
  } idex_t;

  // ALU opcodes read both ra and rb; nothing else reads the register file
  function automatic logic is_alu(input logic [3:0] op);
    return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
  endfunction

endpackage

// File: rtl/id_regfile.sv
// 8x8 register file: two asynchronous read ports, one synchronous write port.
// Build option ID_BYPASS_EN: a read of the register being written this cycle
// returns the incoming write data instead of the stored value.
module id_regfile
  import id_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  // Next register contents: stored value unless the write port targets it
  always_comb begin
    for (int i = 0; i < NREGS; i++) mem_d[i] = mem_q[i];
    if (we) mem_d[waddr] = wdata;
  end

  // Register storage, cleared by the asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Read ports, optionally forwarding the same-cycle write
  always_comb begin
`ifdef ID_BYPASS_EN
    rdata_a = (we && (waddr == raddr_a)) ? wdata : mem_q[raddr_a];
    rdata_b = (we && (waddr == raddr_b)) ? wdata : mem_q[raddr_b];
`else
    rdata_a = mem_q[raddr_a];
    rdata_b = mem_q[raddr_b];
`endif
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: register read, opcode decode, RAW-hazard bubble
// insertion against the instruction currently in the ID/EX slot, and halt.
// Build option ID_BYPASS_EN: register file forwards same-cycle writeback, so a
// hazard costs one bubble cycle; without it the bubble lasts two cycles.
module id_stage
  import id_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       IInst,
  input  logic              IValid,
  output logic              OReady,
  input  logic              IWen,
  input  logic [REG_AW-1:0] IWaddr,
  input  logic [DATA_W-1:0] IWdata,
  input  logic              IStall,
  output logic [DATA_W-1:0] ORa,
  output logic [DATA_W-1:0] ORb,
  output logic [3:0]        OOPALU,
  output logic              ONFCR,
  output logic              OZFCR,
  output logic [REG_AW-1:0] ODst,
  output logic              OWen,
  output logic              OValid,
  output logic              OHalt
);

`ifdef ID_BYPASS_EN
  localparam logic BUB_CNT_INIT = 1'b0;
`else
  localparam logic BUB_CNT_INIT = 1'b1;
`endif

  id_state_e   state_q, state_d;
  idex_t       idex_q, idex_d;
  logic [15:0] hold_q, hold_d;
  logic        cnt_q, cnt_d;

  logic [15:0]       cur_inst;
  logic [3:0]        cur_op;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  idex_t             issue;
  logic [3:0]        in_op;
  logic [REG_AW-1:0] in_ra, in_rb;
  logic              hazard;
  logic              ready;

  // In BUBBLE the held instruction is decoded; otherwise the fetch input
  assign cur_inst = (state_q == ST_BUBBLE) ? hold_q : IInst;
  assign cur_op   = cur_inst[OP_HI:OP_LO];

  id_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (IWen),
    .waddr   (IWaddr),
    .wdata   (IWdata),
    .raddr_a (cur_inst[RA_HI:RA_LO]),
    .raddr_b (cur_inst[RB_HI:RB_LO]),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  // Decode the selected instruction into an ID/EX slot
  always_comb begin
    issue       = '0;
    issue.valid = 1'b1;
    if (is_alu(cur_op)) begin
      issue.opalu = cur_op;
      issue.ra    = rdata_a;
      issue.rb    = rdata_b;
      issue.dst   = cur_inst[RD_HI:RD_LO];
      issue.wen   = 1'b1;
      issue.nfcr  = 1'b1;
      issue.zfcr  = 1'b1;
    end else if (cur_op == OP_LDI) begin
      issue.opalu = ALU_PASS_B;
      issue.rb    = cur_inst[IMM_HI:IMM_LO];
      issue.dst   = cur_inst[RD_HI:RD_LO];
      issue.wen   = 1'b1;
    end
  end

  // RAW hazard: incoming ALU op reads the register the slot is about to write
  always_comb begin
    in_op  = IInst[OP_HI:OP_LO];
    in_ra  = IInst[RA_HI:RA_LO];
    in_rb  = IInst[RB_HI:RB_LO];
    hazard = (state_q == ST_RUN) && IValid && !IStall &&
             idex_q.valid && idex_q.wen && is_alu(in_op) &&
             ((in_ra == idex_q.dst) || (in_rb == idex_q.dst));
  end

  // Next-state, slot load and ready; stall freezes everything
  always_comb begin
    state_d = state_q;
    idex_d  = idex_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    if (!IStall) begin
      case (state_q)
        ST_RUN: begin
          if (hazard) begin
            idex_d  = '0;
            hold_d  = IInst;
            cnt_d   = BUB_CNT_INIT;
            state_d = ST_BUBBLE;
          end else if (!IValid) begin
            idex_d = '0;
            ready  = 1'b1;
          end else begin
            idex_d = issue;
            ready  = 1'b1;
            if (cur_op == OP_HALT) state_d = ST_HALT;
          end
        end
        ST_BUBBLE: begin
          if (cnt_q) begin
            cnt_d  = 1'b0;
            idex_d = '0;
          end else begin
            idex_d  = issue;
            ready   = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_HALT: begin
          idex_d = '0;
        end
        default: begin
          idex_d  = '0;
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Stage registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      idex_q  <= '0;
      hold_q  <= '0;
      cnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idex_q  <= idex_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  assign OReady = rst & ready;
  assign OHalt  = (state_q == ST_HALT);
  assign ORa    = idex_q.ra;
  assign ORb    = idex_q.rb;
  assign OOPALU = idex_q.opalu;
  assign ONFCR  = idex_q.nfcr;
  assign OZFCR  = idex_q.zfcr;
  assign ODst   = idex_q.dst;
  assign OWen   = idex_q.wen;
  assign OValid = idex_q.valid;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage: reset, ALU/LDI/NOP decode, idle bubble,
// stall hold, RAW hazard bubble, halt and reset recovery.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IInst;
  logic        IValid;
  logic        OReady;
  logic        IWen;
  logic [2:0]  IWaddr;
  logic [7:0]  IWdata;
  logic        IStall;
  logic [7:0]  ORa, ORb;
  logic [3:0]  OOPALU;
  logic        ONFCR, OZFCR;
  logic [2:0]  ODst;
  logic        OWen, OValid, OHalt;

  int n_pass  = 0;
  int n_total = 0;

  id_stage dut (
    .clk    (clk),
    .rst    (rst),
    .IInst  (IInst),
    .IValid (IValid),
    .OReady (OReady),
    .IWen   (IWen),
    .IWaddr (IWaddr),
    .IWdata (IWdata),
    .IStall (IStall),
    .ORa    (ORa),
    .ORb    (ORb),
    .OOPALU (OOPALU),
    .ONFCR  (ONFCR),
    .OZFCR  (OZFCR),
    .ODst   (ODst),
    .OWen   (OWen),
    .OValid (OValid),
    .OHalt  (OHalt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic w,
                          input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] d, input logic f);
    chk({tag, ".OValid"}, 16'(OValid), 16'(v));
    chk({tag, ".OWen"},   16'(OWen),   16'(w));
    chk({tag, ".OOPALU"}, 16'(OOPALU), 16'(op));
    chk({tag, ".ORa"},    16'(ORa),    16'(a));
    chk({tag, ".ORb"},    16'(ORb),    16'(b));
    chk({tag, ".ODst"},   16'(ODst),   16'(d));
    chk({tag, ".ONFCR"},  16'(ONFCR),  16'(f));
    chk({tag, ".OZFCR"},  16'(OZFCR),  16'(f));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; IInst = '0; IValid = 1'b0; IWen = 1'b0;
    IWaddr = '0; IWdata = '0; IStall = 1'b0;
    repeat (2) tick();
    chk_slot("reset", 0, 0, 4'h0, 8'h00, 8'h00, 3'd0, 0);
    chk("reset.OHalt", 16'(OHalt), 16'd0);
    chk("reset.OReady", 16'(OReady), 16'd0);
    rst = 1'b1;
    #1 chk("post_reset.OReady", 16'(OReady), 16'd1);

    // R1 = 2, R2 = 2 through the writeback port
    IWen = 1'b1; IWaddr = 3'd1; IWdata = 8'd2;
    tick();
    IWaddr = 3'd2;
    tick();
    IWen = 1'b0;

    // ADD r3,r1,r2
    IValid = 1'b1; IInst = 16'h1650;
    #1 chk("add.OReady", 16'(OReady), 16'd1);
    tick();
    chk_slot("add", 1, 1, 4'h1, 8'd2, 8'd2, 3'd3, 1);

    // LDI r4,0x06
    IInst = 16'hA806;
    tick();
    chk_slot("ldi", 1, 1, 4'h0, 8'd0, 8'd6, 3'd4, 0);

    // NOP opcode 0xB
    IInst = 16'hB123;
    tick();
    chk_slot("nop", 1, 0, 4'h0, 8'd0, 8'd0, 3'd0, 0);

    // No valid input loads a bubble
    IValid = 1'b0;
    tick();
    chk_slot("idle", 0, 0, 4'h0, 8'd0, 8'd0, 3'd0, 0);

    // LDI r6,0x11 then stall for three cycles with LDI r4,0x05 waiting
    IValid = 1'b1; IInst = 16'hAC11;
    tick();
    chk_slot("ldi6", 1, 1, 4'h0, 8'd0, 8'h11, 3'd6, 0);
    IInst = 16'hA905; IStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall.OReady", 16'(OReady), 16'd0);
      tick();
      chk_slot("stall", 1, 1, 4'h0, 8'd0, 8'h11, 3'd6, 0);
    end
    IStall = 1'b0;
    #1 chk("release.OReady", 16'(OReady), 16'd1);
    tick();
    chk_slot("release", 1, 1, 4'h0, 8'd0, 8'd5, 3'd4, 0);

    // ADD r3,r1,r2 followed by SUB r5,r3,r1 -> hazard bubble
    IInst = 16'h1650;
    tick();
    chk_slot("add2", 1, 1, 4'h1, 8'd2, 8'd2, 3'd3, 1);
    IInst = 16'h2AC8;
    #1 chk("hazard.OReady", 16'(OReady), 16'd0);
    tick();
    chk_slot("bubble", 0, 0, 4'h0, 8'd0, 8'd0, 3'd0, 0);
    // downstream writes back r3 = 4
    IWen = 1'b1; IWaddr = 3'd3; IWdata = 8'd4;
`ifndef ID_BYPASS_EN
    #1 chk("bubble2.OReady", 16'(OReady), 16'd0);
    tick();
    chk_slot("bubble2", 0, 0, 4'h0, 8'd0, 8'd0, 3'd0, 0);
    IWen = 1'b0;
`endif
    #1 chk("reissue.OReady", 16'(OReady), 16'd1);
    tick();
    IWen = 1'b0;
    chk_slot("sub", 1, 1, 4'h2, 8'd4, 8'd2, 3'd5, 1);

    // HALT issues as a NOP, then the stage stays halted
    IInst = 16'hE000;
    #1 chk("halt.OReady", 16'(OReady), 16'd1);
    tick();
    chk_slot("halt_issue", 1, 0, 4'h0, 8'd0, 8'd0, 3'd0, 0);
    chk("halt_issue.OHalt", 16'(OHalt), 16'd1);
    IInst = 16'h1650;
    for (int i = 0; i < 3; i++) begin
      #1 chk("halted.OReady", 16'(OReady), 16'd0);
      tick();
      chk("halted.OValid", 16'(OValid), 16'd0);
      chk("halted.OHalt", 16'(OHalt), 16'd1);
    end

    // Reset pulse leaves HALT and clears outputs and registers
    rst = 1'b0;
    #1;
    chk_slot("rst_pulse", 0, 0, 4'h0, 8'd0, 8'd0, 3'd0, 0);
    chk("rst_pulse.OHalt", 16'(OHalt), 16'd0);
    tick();
    rst = 1'b1;
    #1 chk("rst_release.OReady", 16'(OReady), 16'd1);
    tick();
    chk_slot("post_rst_add", 1, 1, 4'h1, 8'd0, 8'd0, 3'd3, 1);
    chk("post_rst.OHalt", 16'(OHalt), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
